key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter N, default 4: number of button channels; bit order is u,d,l,r for bits 0..3.
REQ-002 Parameter DB_CYCLES, default 250000: consecutive stable cycles needed to accept a level change (10 ms at 25 MHz).
REQ-003 Parameter REP_DELAY, default 5000000: cycles from accepted press to first auto-repeat (200 ms).
REQ-004 Parameter REP_PERIOD, default 1250000: cycles between later auto-repeats (50 ms).
REQ-005 Parameter REP_EN, default 4'b1110: per-channel auto-repeat enable; d, l and r repeat, u does not.
REQ-006 clk  input  1  single system clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 btn  input  N  raw, asynchronous, bouncing button levels; 1 = pressed.
REQ-009 level  output  N  debounced button state, registered.
REQ-010 press  output  N  one-cycle pulse on each accepted press and on each auto-repeat, registered.
REQ-011 release  output  N  one-cycle pulse on each accepted release, registered.

Function
REQ-012 Each btn bit passes through its own 2-flop synchronizer, giving s[i]; channels share no state.
REQ-013 Per channel, a debounce counter increments each cycle s[i] != level[i] and clears each cycle s[i] == level[i].
REQ-014 When s[i] has differed from level[i] for DB_CYCLES consecutive cycles, level[i] takes s[i] on that edge and the counter clears.
REQ-015 Any glitch shorter than DB_CYCLES cycles clears the counter and changes no output.
REQ-016 Latency from a clean btn edge to the level change is 2 + DB_CYCLES cycles; width is exactly DB_CYCLES cycles after synchronization.
REQ-017 press[i] is high for exactly one cycle, on the same edge where level[i] rises.
REQ-018 release[i] is high for exactly one cycle, on the same edge where level[i] falls.
REQ-019 Repeat FSM per channel has three states: IDLE, DELAY and REPEAT, with a repeat counter sized for max(REP_DELAY, REP_PERIOD).
REQ-020 IDLE -> DELAY on rising level[i] when REP_EN[i] = 1; the repeat counter clears.
REQ-021 DELAY: the counter increments every cycle; REP_DELAY cycles after the rise, press[i] pulses, the state goes to REPEAT and the counter clears.
REQ-022 REPEAT: press[i] pulses every REP_PERIOD cycles while level[i] stays 1.
REQ-023 Any state -> IDLE on the edge where level[i] falls; the counter clears and no repeat pulse is issued on that edge.
REQ-024 When REP_EN[i] = 0, the FSM stays in IDLE and press[i] pulses only once per accepted press.
REQ-025 press[i] and release[i] are never high in the same cycle.
REQ-026 Counters saturate at their terminal count and never wrap; no overflow is possible for legal parameters.
REQ-027 DB_CYCLES, REP_DELAY and REP_PERIOD are each >= 1; counter widths come from the parameters via clog2.
REQ-028 Simultaneous events on different channels are handled independently in the same cycle.

Reset
REQ-029 While rst = 0, all outputs, synchronizer flops, counters and FSMs are cleared at once (level = 0, press = 0, release = 0, FSM = IDLE), regardless of clk.
REQ-030 A button held through reset release is treated as a fresh press: press pulses 2 + DB_CYCLES cycles after rst rises.
REQ-031 Reset asserted mid-debounce or mid-repeat abandons the operation and produces no pulse on reset entry or exit.

Verification (bench parameters: N=4, DB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3)
REQ-032 btn[2] goes 0->1 and is held clean -> level[2]=1 and a press[2] pulse 6 cycles after the edge; then press[2] pulses at +10, +13 and +16 cycles after the level rise.
REQ-033 btn[1] toggles with a 3-cycle high, a 1-cycle low, then stays high -> no output during the bounce; level[1] rises 4 cycles after the stable-high synchronized edge.
REQ-034 btn[0] (REP_EN=0) is held for 40 cycles, then released -> exactly one press[0], no repeats, and one release[0] 6 cycles after the falling edge.
REQ-035 btn[3] is released 2 cycles before the first repeat is due -> release[3] pulses, no press[3] at the repeat point, and the FSM returns to IDLE.
REQ-036 rst is pulled low while btn[2] is in REPEAT with btn held -> outputs go to 0 immediately; after rst rises, a single press[2] comes 6 cycles later and the repeat sequence restarts from DELAY.
REQ-037 btn[1] and btn[3] rise on the same edge -> press[1] and press[3] pulse in the same cycle, with identical repeat timing on both channels.

Source files
------------

// File: rtl/key_conditioner.sv
// Multi-channel push-button conditioner: 2-flop synchronizer, debounce and
// per-channel auto-repeat, producing registered level, press and release outputs.
module key_conditioner #(
  parameter int          N          = 4,
  parameter int          DB_CYCLES  = 250000,
  parameter int          REP_DELAY  = 5000000,
  parameter int          REP_PERIOD = 1250000,
  parameter logic [N-1:0] REP_EN    = 4'b1110
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse
);

  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_ZERO   = {DB_W{1'b0}};
  localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] PER_LAST  = REP_W'(REP_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0] REP_ZERO  = {REP_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  for (genvar i = 0; i < N; i++) begin : g_ch
    localparam bit REP_ON = REP_EN[i];

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic [DB_W-1:0]  db_cnt_r;
    logic             diff_s;
    logic             db_done_s;
    logic             rise_s;
    logic             fall_s;
    logic             rep_fire_s;
    rep_state_e       state_r;
    rep_state_e       state_nxt_s;
    logic [REP_W-1:0] rep_cnt_r;
    logic [REP_W-1:0] rep_cnt_nxt_s;

    // Two-flop synchronizer for the raw button level
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_r <= 1'b0;
        sync2_r <= 1'b0;
      end else begin
        sync1_r <= btn[i];
        sync2_r <= sync1_r;
      end
    end

    // Debounce qualification: accept a change on the DB_CYCLES-th differing cycle
    always_comb begin
      diff_s    = sync2_r ^ level_r;
      db_done_s = diff_s & (db_cnt_r == DB_LAST);
      rise_s    = db_done_s & sync2_r;
      fall_s    = db_done_s & ~sync2_r;
    end

    // Debounce counter and accepted level
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        db_cnt_r <= DB_ZERO;
        level_r  <= 1'b0;
      end else if (!diff_s) begin
        db_cnt_r <= DB_ZERO;
      end else if (db_done_s) begin
        db_cnt_r <= DB_ZERO;
        level_r  <= sync2_r;
      end else if (db_cnt_r < DB_LAST) begin
        db_cnt_r <= db_cnt_r + DB_ONE;
      end else begin
        db_cnt_r <= db_cnt_r;
      end
    end

    // Repeat FSM state and counter register
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_r   <= ST_IDLE;
        rep_cnt_r <= REP_ZERO;
      end else begin
        state_r   <= state_nxt_s;
        rep_cnt_r <= rep_cnt_nxt_s;
      end
    end

    // Repeat FSM next-state; a falling level always wins over a due repeat
    always_comb begin
      state_nxt_s   = state_r;
      rep_cnt_nxt_s = rep_cnt_r;
      case (state_r)
        ST_IDLE: begin
          if (rise_s && REP_ON) begin
            state_nxt_s   = ST_DELAY;
            rep_cnt_nxt_s = REP_ZERO;
          end else begin
            rep_cnt_nxt_s = REP_ZERO;
          end
        end
        ST_DELAY: begin
          if (fall_s) begin
            state_nxt_s   = ST_IDLE;
            rep_cnt_nxt_s = REP_ZERO;
          end else if (rep_cnt_r >= DLY_LAST) begin
            state_nxt_s   = ST_REPEAT;
            rep_cnt_nxt_s = REP_ZERO;
          end else begin
            rep_cnt_nxt_s = rep_cnt_r + REP_ONE;
          end
        end
        ST_REPEAT: begin
          if (fall_s) begin
            state_nxt_s   = ST_IDLE;
            rep_cnt_nxt_s = REP_ZERO;
          end else if (rep_cnt_r >= PER_LAST) begin
            rep_cnt_nxt_s = REP_ZERO;
          end else begin
            rep_cnt_nxt_s = rep_cnt_r + REP_ONE;
          end
        end
        default: begin
          state_nxt_s   = ST_IDLE;
          rep_cnt_nxt_s = REP_ZERO;
        end
      endcase
    end

    // Repeat FSM output: auto-repeat pulse request
    always_comb begin
      rep_fire_s = 1'b0;
      case (state_r)
        ST_DELAY:  rep_fire_s = ~fall_s & (rep_cnt_r >= DLY_LAST);
        ST_REPEAT: rep_fire_s = ~fall_s & (rep_cnt_r >= PER_LAST);
        default:   rep_fire_s = 1'b0;
      endcase
    end

    // Registered press and release pulses
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        press_r   <= rise_s | rep_fire_s;
        release_r <= fall_s;
      end
    end

    assign level[i]         = level_r;
    assign press[i]         = press_r;
    assign release_pulse[i] = release_r;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Randomized and directed bench for key_conditioner, checked against a
// sample-window / elapsed-time reference model.
module tb_key_conditioner;

  localparam int         N          = 4;
  localparam int         DB         = 4;
  localparam int         RDLY       = 10;
  localparam int         RPER       = 3;
  localparam logic [3:0] REP_EN_P   = 4'b1110;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] release_pulse;

  key_conditioner #(
    .N(N), .DB_CYCLES(DB), .REP_DELAY(RDLY), .REP_PERIOD(RPER), .REP_EN(REP_EN_P)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .level(level), .press(press), .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_bad;
  int         t;
  int         t_rst;
  logic [3:0] hist [0:8191];
  logic [3:0] m_level;
  logic [3:0] m_press;
  logic [3:0] m_rel;
  int         rise_t [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  // Synchronized sample seen by the debouncer at edge tt
  function automatic logic s_at(input int tt, input int i);
    if (tt - 2 >= t_rst) return hist[tt-2][i];
    else return 1'b0;
  endfunction

  // Level flips once the last DB samples all disagree with it; repeats follow elapsed time since the rise
  task automatic model_edge();
    logic [3:0] nl;
    nl = m_level;
    for (int i = 0; i < N; i++) begin
      bit all_diff;
      bit rise;
      bit fall;
      int d;
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) begin
        if ((t - k) < t_rst || s_at(t - k, i) == m_level[i]) all_diff = 1'b0;
      end
      rise = all_diff && !m_level[i];
      fall = all_diff && m_level[i];
      d = t - rise_t[i];
      m_press[i] = rise || (REP_EN_P[i] && m_level[i] && !fall && d >= RDLY && ((d - RDLY) % RPER) == 0);
      m_rel[i] = fall;
      if (rise) begin
        nl[i] = 1'b1;
        rise_t[i] = t;
      end
      if (fall) nl[i] = 1'b0;
    end
    m_level = nl;
  endtask

  task automatic step();
    hist[t+1] = btn;
    @(posedge clk);
    t = t + 1;
    #1;
    model_edge();
    check_eq("level", 32'(level), 32'(m_level));
    check_eq("press", 32'(press), 32'(m_press));
    check_eq("release", 32'(release_pulse), 32'(m_rel));
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    m_level = 4'b0000;
    m_press = 4'b0000;
    m_rel   = 4'b0000;
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_press", 32'(press), 32'd0);
    check_eq("rst_release", 32'(release_pulse), 32'd0);
    repeat (2) begin
      @(posedge clk);
      t = t + 1;
    end
    @(negedge clk);
    rst = 1'b1;
    t_rst = t + 1;
  endtask

  int hold [4];
  int cnt;
  logic any_out;

  initial begin
    n_cmp = 0; n_bad = 0; t = 0; t_rst = 1;
    rst = 1'b0; btn = 4'b0000;
    m_level = 4'b0000; m_press = 4'b0000; m_rel = 4'b0000;
    for (int i = 0; i < N; i++) rise_t[i] = 0;
    do_reset();

    // Clean press on channel 2: press at +6, repeats at +10/+13/+16 after the rise
    btn[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check_eq("a_level_early", 32'(level[2]), 32'd0);
      if (k == 6) check_eq("a_press_rise", 32'({level[2], press[2]}), 32'd3);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 10 || k == 13 || k == 16) check_eq("a_repeat", 32'(press[2]), 32'd1);
      if (k == 11) check_eq("a_gap", 32'(press[2]), 32'd0);
    end

    // Reset while channel 2 repeats, button still held: fresh press and restart from DELAY
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check_eq("b_level_early", 32'(level[2]), 32'd0);
      if (k == 6) check_eq("b_press_fresh", 32'(press[2]), 32'd1);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 3) check_eq("b_no_old_sched", 32'(press[2]), 32'd0);
      if (k == 10) check_eq("b_first_repeat", 32'(press[2]), 32'd1);
    end
    btn[2] = 1'b0;
    repeat (12) step();

    // Bouncy press on channel 1: 3 high, 1 low, then stable high
    any_out = 1'b0;
    btn[1] = 1'b1;
    repeat (3) begin step(); any_out |= press[1] | level[1] | release_pulse[1]; end
    btn[1] = 1'b0;
    step(); any_out |= press[1] | level[1] | release_pulse[1];
    btn[1] = 1'b1;
    repeat (5) begin step(); any_out |= press[1] | level[1] | release_pulse[1]; end
    check_eq("c_bounce_quiet", 32'(any_out), 32'd0);
    step();
    check_eq("c_level_rise", 32'({level[1], press[1]}), 32'd3);
    btn[1] = 1'b0;
    repeat (12) step();

    // Channel 0 (no repeat) held 40 cycles then released
    cnt = 0;
    btn[0] = 1'b1;
    repeat (40) begin step(); cnt += int'(press[0]); end
    check_eq("d_single_press", 32'(cnt), 32'd1);
    btn[0] = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k < 6) cnt += int'(release_pulse[0]);
      if (k == 6) check_eq("d_release", 32'({level[0], release_pulse[0]}), 32'd1);
    end
    check_eq("d_early_release", 32'(cnt), 32'd0);

    // Channel 3 released so that the fall lands 2 cycles before the first repeat
    btn[3] = 1'b1;
    repeat (6) step();
    check_eq("e_press", 32'(press[3]), 32'd1);
    repeat (2) step();
    btn[3] = 1'b0;
    repeat (6) step();
    check_eq("e_release", 32'(release_pulse[3]), 32'd1);
    repeat (2) step();
    check_eq("e_no_repeat", 32'(press[3]), 32'd0);
    cnt = 0;
    repeat (10) begin step(); cnt += int'(press[3]); end
    check_eq("e_idle_quiet", 32'(cnt), 32'd0);

    // Channels 1 and 3 pressed on the same edge
    btn[1] = 1'b1; btn[3] = 1'b1;
    repeat (6) step();
    check_eq("f_press_both", 32'({press[3], press[1]}), 32'd3);
    repeat (10) step();
    check_eq("f_rep_both", 32'({press[3], press[1]}), 32'd3);
    repeat (3) step();
    check_eq("f_rep2_both", 32'({press[3], press[1]}), 32'd3);
    btn[1] = 1'b0; btn[3] = 1'b0;
    repeat (12) step();

    // Randomized mix of bounces and long holds with occasional async reset
    for (int i = 0; i < N; i++) hold[i] = int'($urandom_range(1, 30));
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      for (int i = 0; i < N; i++) begin
        hold[i] = hold[i] - 1;
        if (hold[i] <= 0) begin
          btn[i] = ~btn[i];
          if ($urandom_range(0, 3) == 0) hold[i] = int'($urandom_range(1, 4));
          else hold[i] = int'($urandom_range(5, 40));
        end
      end
      if ((cyc % 500) == 250) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
